// File: rtl/bcd_timer_ctrl.sv
// Start/pause/stop sequencer for a bank of cascaded BCD up/down counters:
// countdown timer or count-up stopwatch with a terminal-value alarm.
module bcd_timer_ctrl #(
  parameter int NDIG = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [4*NDIG-1:0] set_val,
  input  logic [4*NDIG-1:0] cnt_q,
  input  logic [NDIG-1:0]   cnt_co,
  output logic              cnt_ud,
  output logic              cnt_ld,
  output logic [NDIG-1:0]   cnt_en,
  output logic [4*NDIG-1:0] cnt_d,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_mode;
  logic [4*NDIG-1:0] r_tgt;
  logic              w_capture;
  logic              w_term;
  logic [NDIG-1:0]   w_cascade;
  logic              w_acc;
  logic              w_unused;

  function automatic logic [4*NDIG-1:0] clamp_bcd(input logic [4*NDIG-1:0] v);
    logic [4*NDIG-1:0] r;
    r = v;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // The top digit's CO has no higher digit to gate.
  assign w_unused = cnt_co[NDIG-1];

  always_comb begin
    w_acc = tick;
    w_cascade = '0;
    for (int i = 0; i < NDIG; i++) begin
      w_cascade[i] = w_acc;
      w_acc = w_acc & cnt_co[i];
    end
  end

  assign w_term = r_mode ? (cnt_q == r_tgt) : (cnt_q == '0);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_tgt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_mode <= mode;
        r_tgt  <= clamp_bcd(set_val);
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    cnt_ld    = 1'b0;
    cnt_en    = '0;
    cnt_d     = '0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_next    = S_LOAD;
          w_capture = 1'b1;
        end
      end
      S_LOAD: begin
        // Counters only accept a load while enabled.
        cnt_ld = 1'b1;
        cnt_en = '1;
        cnt_d  = r_mode ? '0 : r_tgt;
        w_next = S_RUN;
      end
      S_RUN: begin
        if (w_term)    w_next = S_DONE;
        else if (stop) w_next = S_PAUSE;
        else           cnt_en = w_cascade;
      end
      S_PAUSE: begin
        if (stop)       w_next = S_IDLE;
        else if (start) w_next = S_RUN;
      end
      S_DONE: begin
        if (stop) begin
          w_next = S_IDLE;
        end else if (start) begin
          w_next    = S_LOAD;
          w_capture = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign cnt_ud = r_mode;
  assign busy   = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_PAUSE);
  assign done   = (r_state == S_DONE);
  assign state  = r_state;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl driving a behavioural two-digit BCD
// counter bank; expectations are queued at stimulus time and popped on check.
module tb_bcd_timer_ctrl;
  localparam int NDIG = 2;

  logic              clk, clr, tick, start, stop, mode;
  logic [4*NDIG-1:0] set_val, cnt_q, cnt_d;
  logic [NDIG-1:0]   cnt_co, cnt_en;
  logic              cnt_ud, cnt_ld, busy, done;
  logic [2:0]        state;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;
  sb_t sb[$];

  bcd_timer_ctrl #(.NDIG(NDIG)) dut (
    .clk(clk), .clr(clr), .tick(tick), .start(start), .stop(stop),
    .mode(mode), .set_val(set_val), .cnt_q(cnt_q), .cnt_co(cnt_co),
    .cnt_ud(cnt_ud), .cnt_ld(cnt_ld), .cnt_en(cnt_en), .cnt_d(cnt_d),
    .busy(busy), .done(done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter bank: en gates everything, ld beats ud, wrap 9->0 / 0->9.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) cnt_q <= '0;
    else begin
      for (int i = 0; i < NDIG; i++) begin
        if (cnt_en[i]) begin
          if (cnt_ld)      cnt_q[4*i +: 4] <= cnt_d[4*i +: 4];
          else if (cnt_ud) cnt_q[4*i +: 4] <= (cnt_q[4*i +: 4] == 4'd9) ? 4'd0 : cnt_q[4*i +: 4] + 4'd1;
          else             cnt_q[4*i +: 4] <= (cnt_q[4*i +: 4] == 4'd0) ? 4'd9 : cnt_q[4*i +: 4] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    cnt_co = '0;
    for (int i = 0; i < NDIG; i++)
      cnt_co[i] = cnt_ud ? (cnt_q[4*i +: 4] == 4'd9) : (cnt_q[4*i +: 4] == 4'd0);
  end

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic push(input string t, input logic [31:0] v);
    sb_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    sb_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    push(t, exp);
    pop_chk(obs);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
    tick = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic tick_step(input string t, input logic [NDIG-1:0] en_exp, input logic [7:0] q_exp);
    tick = 1'b1;
    push({t, "_en"}, 32'(en_exp));
    push({t, "_q"}, 32'(q_exp));
    #1;
    pop_chk(32'(cnt_en));
    edge_step();
    pop_chk(32'(cnt_q));
  endtask

  initial begin
    clr = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; set_val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_en", 32'(cnt_en), 0);
    chk("rst_ld", 32'(cnt_ld), 0);
    chk("rst_d", 32'(cnt_d), 0);
    chk("rst_ud", 32'(cnt_ud), 0);
    clr = 1'b1;
    edge_step();

    // Countdown 12 -> 00
    mode = 1'b0; set_val = 8'h12; start = 1'b1;
    push("t1_load_state", 1);
    edge_step();
    pop_chk(32'(state));
    chk("t1_ld", 32'(cnt_ld), 1);
    chk("t1_load_en", 32'(cnt_en), 2'b11);
    chk("t1_d", 32'(cnt_d), 8'h12);
    chk("t1_busy", 32'(busy), 1);
    push("t1_run_state", 2);
    push("t1_run_q", 8'h12);
    edge_step();
    pop_chk(32'(state));
    pop_chk(32'(cnt_q));
    for (int v = 12; v >= 1; v--)
      tick_step("t1_tick", (v % 10 == 0) ? 2'b11 : 2'b01, bcd(v - 1));
    chk("t1_at0_state", 32'(state), 2);
    tick_step("t1_term_tick", 2'b00, 8'h00);
    chk("t1_done_state", 32'(state), 4);
    chk("t1_done", 32'(done), 1);
    chk("t1_done_busy", 32'(busy), 0);
    tick_step("t1_done_tick", 2'b00, 8'h00);

    // Stopwatch 00 -> 25
    mode = 1'b1; set_val = 8'h25; start = 1'b1;
    edge_step();
    chk("t2_load_state", 32'(state), 1);
    chk("t2_ud", 32'(cnt_ud), 1);
    chk("t2_d", 32'(cnt_d), 8'h00);
    edge_step();
    chk("t2_run_q", 32'(cnt_q), 8'h00);
    for (int v = 0; v <= 24; v++)
      tick_step("t2_tick", (v % 10 == 9) ? 2'b11 : 2'b01, bcd(v + 1));
    tick_step("t2_term_tick", 2'b00, 8'h25);
    chk("t2_done_state", 32'(state), 4);
    chk("t2_done", 32'(done), 1);

    // Countdown 30 with pause/resume/abort
    mode = 1'b0; set_val = 8'h30; start = 1'b1;
    edge_step();
    edge_step();
    chk("t3_run_q", 32'(cnt_q), 8'h30);
    for (int v = 30; v >= 26; v--)
      tick_step("t3_tick", (v % 10 == 0) ? 2'b11 : 2'b01, bcd(v - 1));
    stop = 1'b1; tick = 1'b1;
    push("t3_stop_en", 0);
    push("t3_pause_state", 3);
    push("t3_pause_q", 8'h25);
    #1;
    pop_chk(32'(cnt_en));
    edge_step();
    pop_chk(32'(state));
    pop_chk(32'(cnt_q));
    for (int k = 0; k < 3; k++) tick_step("t3_pause_tick", 2'b00, 8'h25);
    chk("t3_still_pause", 32'(state), 3);
    start = 1'b1;
    edge_step();
    chk("t3_resume_state", 32'(state), 2);
    tick_step("t3_resume_tick", 2'b01, 8'h24);
    stop = 1'b1;
    edge_step();
    chk("t3_pause2", 32'(state), 3);
    stop = 1'b1;
    edge_step();
    chk("t3_abort_state", 32'(state), 0);
    chk("t3_abort_q", 32'(cnt_q), 8'h24);

    // Clamped preset, then zero preset
    mode = 1'b0; set_val = 8'hA7; start = 1'b1;
    edge_step();
    chk("t4_load_state", 32'(state), 1);
    chk("t4_clamp_d", 32'(cnt_d), 8'h97);
    edge_step();
    chk("t4_clamp_q", 32'(cnt_q), 8'h97);
    stop = 1'b1;
    edge_step();
    stop = 1'b1;
    edge_step();
    chk("t4_idle", 32'(state), 0);
    set_val = 8'h00; start = 1'b1;
    edge_step();
    chk("t4_z_load", 32'(state), 1);
    edge_step();
    chk("t4_z_run", 32'(state), 2);
    tick = 1'b1;
    #1;
    chk("t4_z_en", 32'(cnt_en), 0);
    edge_step();
    chk("t4_z_done_state", 32'(state), 4);
    chk("t4_z_done", 32'(done), 1);
    chk("t4_z_q", 32'(cnt_q), 8'h00);

    // start+stop in DONE, then async clear during RUN
    start = 1'b1; stop = 1'b1;
    edge_step();
    chk("t5_startstop_idle", 32'(state), 0);
    mode = 1'b0; set_val = 8'h05; start = 1'b1;
    edge_step();
    edge_step();
    chk("t5_run", 32'(state), 2);
    tick = 1'b1;
    #1;
    chk("t5_run_en", 32'(cnt_en), 2'b01);
    #2;
    clr = 1'b0;
    #1;
    chk("t5_clr_state", 32'(state), 0);
    chk("t5_clr_en", 32'(cnt_en), 0);
    chk("t5_clr_busy", 32'(busy), 0);
    chk("t5_clr_q", 32'(cnt_q), 0);
    #1;
    clr = 1'b1; tick = 1'b0;
    edge_step();
    chk("t5_after_clr", 32'(state), 0);

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
